// File: rtl/vga_sync_monitor_if.sv
`default_nettype none
// ============================================================================
// Module   : vga_sync_monitor_if
// Brief    : Sync inputs and recovered-timing outputs of vga_sync_monitor.
// Revision : 1.0  initial release
// ============================================================================
interface vga_sync_monitor_if;
    logic        hsync_in;
    logic        vsync_in;
    logic [9:0]  x;
    logic [9:0]  y;
    logic        visible;
    logic        locked;
    logic [10:0] line_len;
    logic [9:0]  frame_lines;
    logic [7:0]  err_cnt;
    logic        timeout;

    modport master (
        output hsync_in, vsync_in,
        input  x, y, visible, locked, line_len, frame_lines, err_cnt, timeout
    );

    modport slave (
        input  hsync_in, vsync_in,
        output x, y, visible, locked, line_len, frame_lines, err_cnt, timeout
    );
endinterface
`default_nettype wire

// File: rtl/vga_sync_monitor.sv
`default_nettype none
// ============================================================================
// Module   : vga_sync_monitor
// Brief    : Recovers x/y from VGA syncs, measures line/frame timing and locks
//            when it matches the parameters. VGA_MON_TIMEOUT_EN adds a watchdog.
// Revision : 1.0  initial release
// ============================================================================
module vga_sync_monitor #(
    parameter int H_TOTAL      = 800,
    parameter int V_TOTAL      = 525,
    parameter int H_VISIBLE    = 640,
    parameter int V_VISIBLE    = 480,
    parameter int H_SYNC_START = 656,
    parameter int V_SYNC_START = 490,
    parameter int LOCK_FRAMES  = 2
) (
    input wire                clk,
    input wire                rst,
    vga_sync_monitor_if.slave mon
);
    localparam logic [1:0]  c_SEARCH      = 2'd0;
    localparam logic [1:0]  c_MEASURE     = 2'd1;
    localparam logic [1:0]  c_LOCKED      = 2'd2;
    localparam logic [9:0]  c_H_LAST      = 10'(H_TOTAL - 1);
    localparam logic [9:0]  c_V_LAST      = 10'(V_TOTAL - 1);
    localparam logic [9:0]  c_H_SYNC      = 10'(H_SYNC_START);
    localparam logic [9:0]  c_V_SYNC      = 10'(V_SYNC_START);
    localparam logic [9:0]  c_H_VIS       = 10'(H_VISIBLE);
    localparam logic [9:0]  c_V_VIS       = 10'(V_VISIBLE);
    localparam logic [10:0] c_LINE_LEN    = 11'(H_TOTAL);
    localparam logic [9:0]  c_FRAME_LINES = 10'(V_TOTAL);
    localparam logic [7:0]  c_LOCK_FRAMES = 8'(LOCK_FRAMES);

    logic        r_hs1, r_hs2, r_vs1, r_vs2;
    logic        w_hfall, w_vfall;
    logic [9:0]  r_x, r_y;
    logic [10:0] r_line_cnt, r_line_len;
    logic [9:0]  r_frame_cnt, r_frame_lines, w_frame_total;
    logic        r_frame_bad, w_line_bad, w_frame_bad;
    logic [1:0]  r_state;
    logic [7:0]  r_good, w_good_next, r_err_cnt;
    logic        r_locked;
    logic        w_wd_force;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hs1 <= 1'b1;
            r_hs2 <= 1'b1;
            r_vs1 <= 1'b1;
            r_vs2 <= 1'b1;
        end else begin
            r_hs1 <= mon.hsync_in;
            r_hs2 <= r_hs1;
            r_vs1 <= mon.vsync_in;
            r_vs2 <= r_vs1;
        end
    end

    assign w_hfall = r_hs2 & ~r_hs1;
    assign w_vfall = r_vs2 & ~r_vs1;

    // An hsync edge landing on the wrap cycle reloads x, so y must not step.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_x <= '0;
            r_y <= '0;
        end else begin
            if (w_hfall)
                r_x <= c_H_SYNC;
            else if (r_x == c_H_LAST)
                r_x <= '0;
            else
                r_x <= r_x + 10'd1;

            if (w_vfall)
                r_y <= c_V_SYNC;
            else if (!w_hfall && r_x == c_H_LAST)
                r_y <= (r_y == c_V_LAST) ? 10'd0 : r_y + 10'd1;
        end
    end

    assign w_line_bad    = w_hfall && (r_line_cnt != c_LINE_LEN);
    assign w_frame_total = (w_hfall && r_frame_cnt != 10'h3FF) ? r_frame_cnt + 10'd1 : r_frame_cnt;
    assign w_frame_bad   = r_frame_bad || w_line_bad || (w_frame_total != c_FRAME_LINES);
    assign w_good_next   = r_good + 8'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_line_cnt    <= '0;
            r_line_len    <= '0;
            r_frame_cnt   <= '0;
            r_frame_lines <= '0;
            r_frame_bad   <= 1'b0;
        end else begin
            if (w_hfall) begin
                r_line_len <= r_line_cnt;
                r_line_cnt <= 11'd1;
            end else if (r_line_cnt != 11'h7FF) begin
                r_line_cnt <= r_line_cnt + 11'd1;
            end

            if (w_vfall) begin
                r_frame_lines <= w_frame_total;
                r_frame_cnt   <= '0;
                r_frame_bad   <= 1'b0;
            end else begin
                r_frame_cnt <= w_frame_total;
                if (w_line_bad)
                    r_frame_bad <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= c_SEARCH;
            r_good    <= '0;
            r_locked  <= 1'b0;
            r_err_cnt <= '0;
        end else if (w_wd_force) begin
            if (r_state == c_LOCKED && r_err_cnt != 8'hFF)
                r_err_cnt <= r_err_cnt + 8'd1;
            r_state  <= c_SEARCH;
            r_locked <= 1'b0;
        end else begin
            case (r_state)
                c_SEARCH: begin
                    if (w_vfall) begin
                        r_state <= c_MEASURE;
                        r_good  <= '0;
                    end
                end
                c_MEASURE: begin
                    if (w_vfall) begin
                        if (w_frame_bad) begin
                            r_good <= '0;
                        end else begin
                            r_good <= w_good_next;
                            if (w_good_next >= c_LOCK_FRAMES) begin
                                r_state  <= c_LOCKED;
                                r_locked <= 1'b1;
                            end
                        end
                    end
                end
                c_LOCKED: begin
                    if (w_line_bad || (w_vfall && w_frame_bad)) begin
                        r_state  <= c_SEARCH;
                        r_locked <= 1'b0;
                        if (r_err_cnt != 8'hFF)
                            r_err_cnt <= r_err_cnt + 8'd1;
                    end
                end
                default: begin
                    r_state  <= c_SEARCH;
                    r_locked <= 1'b0;
                end
            endcase
        end
    end

`ifdef VGA_MON_TIMEOUT_EN
    logic [11:0] r_wd_cnt;
    logic        r_timeout;
    logic        w_wd_hit;

    assign w_wd_hit = !w_hfall && (r_wd_cnt == 12'd2047);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wd_cnt  <= '0;
            r_timeout <= 1'b0;
        end else if (w_hfall) begin
            r_wd_cnt  <= '0;
            r_timeout <= 1'b0;
        end else if (r_wd_cnt != 12'd2048) begin
            r_wd_cnt <= r_wd_cnt + 12'd1;
            if (w_wd_hit)
                r_timeout <= 1'b1;
        end
    end

    // Hold the FSM in SEARCH until an hsync edge clears the timeout.
    assign w_wd_force  = w_wd_hit || (r_timeout && !w_hfall);
    assign mon.timeout = r_timeout;
`else
    assign w_wd_force  = 1'b0;
    assign mon.timeout = 1'b0;
`endif

    assign mon.x           = r_x;
    assign mon.y           = r_y;
    assign mon.locked      = r_locked;
    assign mon.visible     = r_locked && (r_x < c_H_VIS) && (r_y < c_V_VIS);
    assign mon.line_len    = r_line_len;
    assign mon.frame_lines = r_frame_lines;
    assign mon.err_cnt     = r_err_cnt;
endmodule
`default_nettype wire
